// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Fetch/decode/execute sequencer driving a registered control word.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit #(
  parameter int FETCH_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       z,
  output logic [8:0] ctrlsig,
  output logic       iram_read,
  output logic       pc_inc,
  output logic       pc_reset,
  output logic       ir_we,
  output logic       dr_we,
  output logic       busy,
  output logic       halted,
  output logic       illegal,
  output logic       zero_flag
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC1  = 3'd4,
    S_EXEC2  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] c_WAIT_LAST = 3'(FETCH_WAIT - 1);
  localparam logic [4:0] c_OP_NOP    = 5'b00000;
  localparam logic [4:0] c_OP_LDAC   = 5'b00001;
  localparam logic [4:0] c_OP_STAC   = 5'b00010;
  localparam logic [4:0] c_OP_INCR   = 5'b00011;
  localparam logic [4:0] c_OP_RSTR   = 5'b00100;
  localparam logic [4:0] c_OP_HALT   = 5'b11111;

  state_t     r_state;
  logic [2:0] r_wait_cnt;
  logic [7:0] r_ir;
  logic       r_rst_done;

  state_t     w_next;
  logic [2:0] w_cnt_next;
  logic [7:0] w_ir;
  logic [8:0] w_ctrl;
  logic       w_iram;
  logic       w_load;
  logic       w_busy;
  logic       w_halted;
  logic       w_illegal;
  logic       w_zf;
  logic [4:0] w_op;
  logic       w_alu_class;
  logic       w_unused_operand;

  assign w_op             = r_ir[7:3];
  assign w_alu_class      = (w_op[4:3] == 2'b01);
  assign w_unused_operand = ^r_ir[2:0];

  always_comb begin
    w_next     = r_state;
    w_cnt_next = 3'd0;
    w_ir       = r_ir;
    w_zf       = zero_flag;
    w_ctrl     = 9'd0;
    w_iram     = 1'b0;
    w_load     = 1'b0;
    w_busy     = 1'b0;
    w_halted   = 1'b0;
    w_illegal  = 1'b0;

    case (r_state)
      // start is ignored on the pc_reset cycle straight after reset release
      S_IDLE:   if (r_rst_done && start) w_next = S_FETCH;
      S_FETCH: begin
        if (r_wait_cnt == c_WAIT_LAST) w_next = S_LOAD;
        else                           w_cnt_next = r_wait_cnt + 3'd1;
      end
      S_LOAD: begin
        w_next = S_DECODE;
        w_ir   = instr;
      end
      S_DECODE: w_next = (w_op == c_OP_HALT) ? S_HALT : S_EXEC1;
      S_EXEC1:  w_next = w_alu_class ? S_EXEC2 : S_FETCH;
      S_EXEC2: begin
        w_next = S_FETCH;
        w_zf   = z;
      end
      S_HALT:   if (!start) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they line up with it.
    case (w_next)
      S_FETCH: begin
        w_iram = 1'b1;
        w_busy = 1'b1;
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_busy = 1'b1;
      end
      S_DECODE: w_busy = 1'b1;
      S_EXEC1: begin
        w_busy = 1'b1;
        case (w_op)
          c_OP_NOP:  w_ctrl = 9'b000_000_000;
          c_OP_LDAC: w_ctrl = 9'b100_000_011;
          c_OP_STAC: w_ctrl = 9'b001_000_000;
          c_OP_INCR: w_ctrl = 9'b010_000_000;
          c_OP_RSTR: w_ctrl = 9'b011_000_000;
          default: begin
            if (w_alu_class) w_ctrl = {3'b100, w_op[2:0], 3'b001};
            else             w_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC2: begin
        w_busy = 1'b1;
        w_ctrl = {3'b000, w_op[2:0], 3'b100};
      end
      S_HALT:  w_halted = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 3'd0;
      r_ir       <= 8'd0;
      r_rst_done <= 1'b0;
      ctrlsig    <= 9'd0;
      iram_read  <= 1'b0;
      pc_inc     <= 1'b0;
      pc_reset   <= 1'b0;
      ir_we      <= 1'b0;
      dr_we      <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_cnt_next;
      r_ir       <= w_ir;
      r_rst_done <= 1'b1;
      ctrlsig    <= w_ctrl;
      iram_read  <= w_iram;
      pc_inc     <= w_load;
      pc_reset   <= ~r_rst_done;
      ir_we      <= w_load;
      dr_we      <= w_load;
      busy       <= w_busy;
      halted     <= w_halted;
      illegal    <= w_illegal;
      zero_flag  <= w_zf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Directed self-checking bench for control_unit (FETCH_WAIT 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1;
  logic       start3;
  logic [7:0] instr;
  logic       z;

  logic [8:0] ctrl1, ctrl3;
  logic iram1, pcinc1, pcrst1, irwe1, drwe1, busy1, halted1, ill1, zf1;
  logic iram3, pcinc3, pcrst3, irwe3, drwe3, busy3, halted3, ill3, zf3;

  int n_checks = 0;
  int n_fail   = 0;

  // {ctrlsig, iram_read, pc_inc, pc_reset, ir_we, dr_we, busy, halted, illegal, zero_flag}
  wire [17:0] obs1 = {ctrl1, iram1, pcinc1, pcrst1, irwe1, drwe1, busy1, halted1, ill1, zf1};
  wire [17:0] obs3 = {ctrl3, iram3, pcinc3, pcrst3, irwe3, drwe3, busy3, halted3, ill3, zf3};

  localparam logic [17:0] E_IDLE  = 18'h00000;
  localparam logic [17:0] E_PCRST = 18'h00040;
  localparam logic [17:0] E_FETCH = 18'h00108;
  localparam logic [17:0] E_LOAD  = 18'h000B8;
  localparam logic [17:0] E_DEC   = 18'h00008;
  localparam logic [17:0] E_HALT  = 18'h00004;
  localparam logic [17:0] E_ZF    = 18'h00001;

  control_unit #(.FETCH_WAIT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .instr(instr), .z(z),
    .ctrlsig(ctrl1), .iram_read(iram1), .pc_inc(pcinc1), .pc_reset(pcrst1),
    .ir_we(irwe1), .dr_we(drwe1), .busy(busy1), .halted(halted1),
    .illegal(ill1), .zero_flag(zf1)
  );

  control_unit #(.FETCH_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .instr(instr), .z(z),
    .ctrlsig(ctrl3), .iram_read(iram3), .pc_inc(pcinc3), .pc_reset(pcrst3),
    .ir_we(irwe3), .dr_we(drwe3), .busy(busy3), .halted(halted3),
    .illegal(ill3), .zero_flag(zf3)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] exec_vec(input logic [8:0] c, input logic ill, input logic zf);
    return {c, 5'b00000, 1'b1, 1'b0, ill, zf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] e1 [4];
    logic [17:0] e3 [4];
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs1 !== E_IDLE) begin n_fail++; $display("FAIL reset_hold_fw1: got %h expected %h", obs1, E_IDLE); end
    n_checks++;
    if (obs3 !== E_IDLE) begin n_fail++; $display("FAIL reset_hold_fw3: got %h expected %h", obs3, E_IDLE); end
    reset = 1'b0;
    e1[0] = E_PCRST; e3[0] = E_PCRST;
    e1[1] = E_FETCH; e3[1] = E_IDLE;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs1 !== e1[i]) begin n_fail++; $display("FAIL release_fw1 cycle %0d: got %h expected %h", i, obs1, e1[i]); end
      n_checks++;
      if (obs3 !== e3[i]) begin n_fail++; $display("FAIL release_fw3 cycle %0d: got %h expected %h", i, obs3, e3[i]); end
    end
  endtask

  task automatic test_ldac();
    logic [17:0] e [4];
    e[0] = E_LOAD;
    e[1] = E_DEC;
    e[2] = exec_vec(9'b100_000_011, 1'b0, 1'b0);
    e[3] = E_FETCH;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs1 !== e[i]) begin n_fail++; $display("FAIL ldac cycle %0d: got %h expected %h", i, obs1, e[i]); end
    end
  endtask

  task automatic test_alu();
    logic [17:0] e [5];
    instr = 8'h5A;
    z     = 1'b1;
    e[0] = E_LOAD;
    e[1] = E_DEC;
    e[2] = exec_vec(9'b100_011_001, 1'b0, 1'b0);
    e[3] = exec_vec(9'b000_011_100, 1'b0, 1'b0);
    e[4] = E_FETCH | E_ZF;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs1 !== e[i]) begin n_fail++; $display("FAIL alu cycle %0d: got %h expected %h", i, obs1, e[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [17:0] e [4];
    instr = 8'hA0;
    z     = 1'b0;
    e[0] = E_LOAD | E_ZF;
    e[1] = E_DEC | E_ZF;
    e[2] = exec_vec(9'b0, 1'b1, 1'b1);
    e[3] = E_FETCH | E_ZF;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs1 !== e[i]) begin n_fail++; $display("FAIL illegal cycle %0d: got %h expected %h", i, obs1, e[i]); end
    end
  endtask

  task automatic test_start_drop();
    logic [17:0] e [4];
    instr  = 8'h00;
    start1 = 1'b0;
    e[0] = E_LOAD | E_ZF;
    e[1] = E_DEC | E_ZF;
    e[2] = exec_vec(9'b0, 1'b0, 1'b1);
    e[3] = E_FETCH | E_ZF;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs1 !== e[i]) begin n_fail++; $display("FAIL start_drop cycle %0d: got %h expected %h", i, obs1, e[i]); end
    end
  endtask

  task automatic test_halt();
    logic [17:0] e [7];
    instr  = 8'hF8;
    start1 = 1'b1;
    e[0] = E_LOAD | E_ZF;
    e[1] = E_DEC | E_ZF;
    e[2] = E_HALT | E_ZF;
    e[3] = E_HALT | E_ZF;
    e[4] = E_HALT | E_ZF;
    e[5] = E_IDLE | E_ZF;
    e[6] = E_IDLE | E_ZF;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (obs1 !== e[i]) begin n_fail++; $display("FAIL halt cycle %0d: got %h expected %h", i, obs1, e[i]); end
      if (i == 4) start1 = 1'b0;
    end
  endtask

  task automatic test_fetch_wait3();
    logic [17:0] e [7];
    instr  = 8'h00;
    start3 = 1'b1;
    e[0] = E_FETCH;
    e[1] = E_FETCH;
    e[2] = E_FETCH;
    e[3] = E_LOAD;
    e[4] = E_DEC;
    e[5] = exec_vec(9'b0, 1'b0, 1'b0);
    e[6] = E_FETCH;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (obs3 !== e[i]) begin n_fail++; $display("FAIL fw3 cycle %0d: got %h expected %h", i, obs3, e[i]); end
    end
    n_checks++;
    if (obs1 !== (E_IDLE | E_ZF)) begin n_fail++; $display("FAIL fw3_other_idle: got %h expected %h", obs1, E_IDLE | E_ZF); end
    start3 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [17:0] e [4];
    start1 = 1'b1;
    instr  = 8'h5A;
    z      = 1'b1;
    e[0] = E_FETCH | E_ZF;
    e[1] = E_LOAD | E_ZF;
    e[2] = E_DEC | E_ZF;
    e[3] = exec_vec(9'b100_011_001, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs1 !== e[i]) begin n_fail++; $display("FAIL rst_mid_run cycle %0d: got %h expected %h", i, obs1, e[i]); end
    end
    start1 = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs1 !== E_IDLE) begin n_fail++; $display("FAIL rst_mid_async_fw1: got %h expected %h", obs1, E_IDLE); end
    n_checks++;
    if (obs3 !== E_IDLE) begin n_fail++; $display("FAIL rst_mid_async_fw3: got %h expected %h", obs3, E_IDLE); end
    tick();
    n_checks++;
    if (obs1 !== E_IDLE) begin n_fail++; $display("FAIL rst_mid_held: got %h expected %h", obs1, E_IDLE); end
    reset = 1'b0;
    e[0] = E_PCRST;
    e[1] = E_IDLE;
    e[2] = E_IDLE;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs1 !== e[i]) begin n_fail++; $display("FAIL rst_mid_release cycle %0d: got %h expected %h", i, obs1, e[i]); end
    end
    n_checks++;
    if (obs3 !== E_IDLE) begin n_fail++; $display("FAIL rst_mid_release_fw3: got %h expected %h", obs3, E_IDLE); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    start1 = 1'b1;
    start3 = 1'b0;
    instr  = 8'h0B;
    z      = 1'b0;
    test_reset();
    test_ldac();
    test_alu();
    test_illegal();
    test_start_drop();
    test_halt();
    test_fetch_wait3();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter FETCH_WAIT, default 1, SHALL set the IRAM read latency in cycles (legal range 1-7).
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 Port start  input  1  SHALL be a level request to begin or resume execution from IDLE.
REQ-005 Port instr  input  8  SHALL carry the IRAM read data: opcode = instr[7:3], operand = instr[2:0].
REQ-006 Port z  input  1  SHALL be the ALU zero flag, sampled in EXEC2 only.
REQ-007 Port ctrlsig  output  9  SHALL be the registered datapath control word, with fields:
- [8:6] OPR_sel: 000 none, 001 WTR, 010 INC, 011 RESET, 100 WTA.
- [5:3] alu_op.
- [2] AC ALU-write enable.
- [1] AC bus-write enable.
- [0] WTA enable.
REQ-008 Ports iram_read, pc_inc, pc_reset, ir_we, dr_we  output  1 each  SHALL be registered strobes for the IRAM, PC, IR and DR.
REQ-009 Ports busy, halted, illegal, zero_flag  output  1 each  SHALL be registered status outputs.

Function
REQ-010 The FSM SHALL have states IDLE, FETCH, LOAD, DECODE, EXEC1, EXEC2 and HALT.
REQ-011 Transitions SHALL be:
- IDLE -> FETCH when start=1.
- FETCH -> LOAD after FETCH_WAIT cycles.
- LOAD -> DECODE.
- DECODE -> EXEC1.
- EXEC1 -> EXEC2 for ALU-class opcodes, otherwise -> FETCH.
- EXEC2 -> FETCH.
- DECODE -> HALT for opcode 11111.
- HALT -> IDLE only when start=0.
REQ-012 In FETCH, iram_read SHALL be 1 for every cycle of the state; a 3-bit wait counter SHALL count 0..FETCH_WAIT-1 and clear on exit.
REQ-013 In LOAD, ir_we, dr_we and pc_inc SHALL each be 1 for exactly one cycle, and instr SHALL be captured into an internal IR.
REQ-014 Opcode actions in EXEC1 (ctrlsig values):
- 00000 NOP: 0.
- 00001 LDAC: OPR_sel=100, [1]=1, [0]=1.
- 00010 STAC: OPR_sel=001.
- 00011 INCR: OPR_sel=010.
- 00100 RSTR: OPR_sel=011.
- 01aaa ALU: OPR_sel=100, [0]=1, alu_op=aaa.
REQ-015 In EXEC2 (ALU class only), ctrlsig SHALL hold alu_op=aaa and set [2]=1, and zero_flag SHALL be loaded from z.
REQ-016 Any opcode not listed SHALL execute as NOP and set illegal=1 for exactly the EXEC1 cycle.
REQ-017 In every state other than EXEC1 and EXEC2, ctrlsig SHALL be 9'b0; strobes not named for a state SHALL be 0.
REQ-018 ctrlsig and the strobes SHALL be registered: the value for state S appears in the cycle the FSM is in S, driven from next-state logic.
REQ-019 busy SHALL be 1 in FETCH, LOAD, DECODE, EXEC1 and EXEC2; halted SHALL be 1 only in HALT.
REQ-020 Latency SHALL be FETCH_WAIT+4 cycles per instruction for ALU class and FETCH_WAIT+3 cycles otherwise.
REQ-021 Deasserting start mid-instruction SHALL NOT abort it; the FSM finishes the instruction and fetches the next one (start is checked only in IDLE and HALT).
REQ-022 pc_reset SHALL pulse for one cycle on the first clock after reset deasserts, concurrent with IDLE.

Reset
REQ-023 While reset=1, the FSM SHALL be in IDLE; ctrlsig, the strobes, busy, halted, illegal, zero_flag, the IR and the wait counter SHALL all be 0, including when reset asserts mid-instruction.
REQ-024 The first clock after reset deasserts SHALL assert pc_reset=1 only; start is honoured from the following cycle.

Verification
REQ-025 FETCH_WAIT=1, start=1, instr=8'h0B (LDAC r3) -> iram_read for 1 cycle; ir_we, dr_we and pc_inc for 1 cycle; ctrlsig=9'b100_000_011 for 1 cycle; total 4 cycles.
REQ-026 instr=8'h5A (ALU op 011, r2), z=1 -> EXEC1 ctrlsig=9'b100_011_001, EXEC2 ctrlsig=9'b000_011_100, zero_flag=1 after EXEC2.
REQ-027 FETCH_WAIT=3, instr=8'h00 -> iram_read held 3 cycles, instruction completes in 6 cycles, ctrlsig stays 0.
REQ-028 instr=8'hF8 (HALT) with start held at 1 -> halted=1 and the FSM stays in HALT; start=0 -> IDLE next cycle.
REQ-029 instr=8'hA0 (undefined) -> illegal=1 for 1 cycle, ctrlsig=0, next FETCH follows.
REQ-030 Reset asserted during EXEC1 of an ALU op -> all outputs 0 asynchronously; after release, pc_reset pulses once and no EXEC2 occurs.
